// File: rtl/fifo_pkg.sv
// Shared pointer types and gray-code helpers for the async FIFO write and read controllers.
package fifo_pkg;

  localparam int unsigned FIFO_ADDR_W = 3;
  localparam int unsigned PTR_W       = FIFO_ADDR_W + 1;

  typedef logic [PTR_W-1:0] ptr_t;

  function automatic ptr_t bin2gray(input ptr_t b);
    return b ^ (b >> 1);
  endfunction

  // Each binary bit is the XOR of all gray bits at or above it.
  function automatic ptr_t gray2bin(input ptr_t g);
    ptr_t b;
    b[PTR_W-1] = g[PTR_W-1];
    for (int i = int'(PTR_W) - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/async_fifo_ptr.sv
// Binary/gray pointer register pair with increment enable; shared by both FIFO domains.
module async_fifo_ptr
  import fifo_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  output ptr_t bin,
  output ptr_t gray,
  output ptr_t bin_next_c,
  output ptr_t gray_next_c
);

  always_comb begin
    bin_next_c  = bin + ptr_t'(inc);
    gray_next_c = bin2gray(bin_next_c);
  end

  // Gray copy is a plain flop so the crossing sees a single-bit change per edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin  <= '0;
      gray <= '0;
    end else begin
      bin  <= bin_next_c;
      gray <= gray_next_c;
    end
  end

endmodule

// File: rtl/async_fifo_wctrl.sv
// Write-domain controller of the gray-pointer async FIFO: write pointer, RAM strobe/address, full/level/overflow flags.
module async_fifo_wctrl
  import fifo_pkg::*;
#(
  parameter int unsigned ADDR_W       = FIFO_ADDR_W,  // must equal fifo_pkg::FIFO_ADDR_W
  parameter int unsigned AFULL_THRESH = 6
) (
  input  logic            clk,
  input  logic            arst,
  input  logic            wr_push,
  input  logic            ovf_clr,
  input  logic [ADDR_W:0] rptr_gray_sync,
  output logic            wr_en,
  output logic [ADDR_W-1:0] waddr,
  output logic [ADDR_W:0] wptr_gray,
  output logic            wr_ready,
  output logic            full,
  output logic            almost_full,
  output logic [ADDR_W:0] wr_level,
  output logic            overflow
);

  logic accept;
  ptr_t wbin;
  ptr_t wbin_next;
  ptr_t gray_next;
  ptr_t rbin_sync;
  ptr_t full_cmp;
  ptr_t level_next;

  assign accept = wr_push & ~full;
  assign wr_en  = accept;
  assign waddr  = wbin[ADDR_W-1:0];

  async_fifo_ptr u_wptr (
    .clk         (clk),
    .rst_n       (arst),
    .inc         (accept),
    .bin         (wbin),
    .gray        (wptr_gray),
    .bin_next_c  (wbin_next),
    .gray_next_c (gray_next)
  );

  // Full when the next write pointer sits exactly one lap ahead of the read pointer.
  always_comb begin
    rbin_sync  = gray2bin(rptr_gray_sync);
    full_cmp   = {~rptr_gray_sync[ADDR_W:ADDR_W-1], rptr_gray_sync[ADDR_W-2:0]};
    level_next = wbin_next - rbin_sync;
  end

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      full        <= 1'b0;
      almost_full <= 1'b0;
      wr_level    <= '0;
      overflow    <= 1'b0;
    end else begin
      full        <= (gray_next == full_cmp);
      almost_full <= (level_next >= ptr_t'(AFULL_THRESH));
      wr_level    <= level_next;
      if (wr_push && full) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end
    end
  end

  assign wr_ready = ~full;

endmodule

// File: tb/tb_async_fifo_wctrl.sv
// Directed and model-checked bench for the async FIFO write-domain controller (ADDR_W=3).
module tb_async_fifo_wctrl;

  logic       clk;
  logic       arst;
  logic       wr_push;
  logic       ovf_clr;
  logic [3:0] rptr_gray_sync;
  logic       wr_en;
  logic [2:0] waddr;
  logic [3:0] wptr_gray;
  logic       wr_ready;
  logic       full;
  logic       almost_full;
  logic [3:0] wr_level;
  logic       overflow;

  int checks = 0;
  int errors = 0;

  async_fifo_wctrl #(.ADDR_W(3), .AFULL_THRESH(6)) dut (
    .clk            (clk),
    .arst           (arst),
    .wr_push        (wr_push),
    .ovf_clr        (ovf_clr),
    .rptr_gray_sync (rptr_gray_sync),
    .wr_en          (wr_en),
    .waddr          (waddr),
    .wptr_gray      (wptr_gray),
    .wr_ready       (wr_ready),
    .full           (full),
    .almost_full    (almost_full),
    .wr_level       (wr_level),
    .overflow       (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] tb_b2g(input logic [3:0] b);
    logic [3:0] g;
    g[3] = b[3];
    g[2] = b[3] ^ b[2];
    g[1] = b[2] ^ b[1];
    g[0] = b[1] ^ b[0];
    return g;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    wr_push = 1'b0;
    ovf_clr = 1'b0;
    rptr_gray_sync = 4'h0;
    arst = 1'b0;
    tick();
    tick();
    arst = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    wr_push = 1'b1;
    tick();
    tick();
    tick();
    // Assert reset mid-cycle with a push still requested.
    #3;
    arst = 1'b0;
    #1;
    checks++;
    if (wptr_gray !== 4'h0 || full !== 1'b0 || wr_ready !== 1'b1 || wr_level !== 4'h0 ||
        almost_full !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: gray=%h full=%b ready=%b level=%0d af=%b ovf=%b, want 0 0 1 0 0 0",
               wptr_gray, full, wr_ready, wr_level, almost_full, overflow);
    end
    tick();
    arst = 1'b1;
    #1;
    checks++;
    if (waddr !== 3'd0 || wr_en !== 1'b1) begin
      errors++;
      $display("FAIL reset_first_push: waddr=%0d wr_en=%b, want 0 1", waddr, wr_en);
    end
    tick();
    checks++;
    if (wptr_gray !== 4'h1) begin
      errors++;
      $display("FAIL reset_first_gray: got %h want 1", wptr_gray);
    end
    wr_push = 1'b0;
  endtask

  task automatic test_fill();
    logic [3:0] seq [8];
    seq = '{4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      wr_push = 1'b1;
      #1;
      checks++;
      if (waddr !== 3'(i) || wr_en !== 1'b1) begin
        errors++;
        $display("FAIL fill_waddr[%0d]: waddr=%0d wr_en=%b, want %0d 1", i, waddr, wr_en, i);
      end
      tick();
      checks++;
      if (wptr_gray !== seq[i] || wr_level !== 4'(i + 1) || almost_full !== (i >= 5)) begin
        errors++;
        $display("FAIL fill_state[%0d]: gray=%h level=%0d af=%b, want %h %0d %b",
                 i, wptr_gray, wr_level, almost_full, seq[i], i + 1, (i >= 5));
      end
    end
    checks++;
    if (full !== 1'b1 || wr_ready !== 1'b0 || wr_level !== 4'd8) begin
      errors++;
      $display("FAIL fill_full: full=%b ready=%b level=%0d, want 1 0 8", full, wr_ready, wr_level);
    end
  endtask

  task automatic test_overflow();
    wr_push = 1'b1;
    #1;
    checks++;
    if (wr_en !== 1'b0) begin
      errors++;
      $display("FAIL ovf_wr_en: got %b want 0", wr_en);
    end
    tick();
    checks++;
    if (wptr_gray !== 4'hC || overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_set: gray=%h ovf=%b, want C 1", wptr_gray, overflow);
    end
    ovf_clr = 1'b1;
    tick();
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_set_wins: got %b want 1", overflow);
    end
    wr_push = 1'b0;
    tick();
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clear: got %b want 0", overflow);
    end
    ovf_clr = 1'b0;
  endtask

  task automatic test_drain();
    logic [3:0] rp [3];
    logic [3:0] lv [3];
    logic       af [3];
    rp = '{4'b0001, 4'b0011, 4'b0010};
    lv = '{4'd7, 4'd6, 4'd5};
    af = '{1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      rptr_gray_sync = rp[i];
      tick();
      checks++;
      if (full !== 1'b0 || wr_ready !== 1'b1 || wr_level !== lv[i] || almost_full !== af[i]) begin
        errors++;
        $display("FAIL drain[%0d]: full=%b ready=%b level=%0d af=%b, want 0 1 %0d %b",
                 i, full, wr_ready, wr_level, almost_full, lv[i], af[i]);
      end
    end
  endtask

  task automatic test_wrap();
    rptr_gray_sync = 4'hC;
    tick();
    checks++;
    if (wr_level !== 4'd0 || full !== 1'b0 || almost_full !== 1'b0) begin
      errors++;
      $display("FAIL wrap_empty: level=%0d full=%b af=%b, want 0 0 0", wr_level, full, almost_full);
    end
    for (int i = 0; i < 8; i++) begin
      wr_push = 1'b1;
      #1;
      checks++;
      if (waddr !== 3'(i) || wr_en !== 1'b1) begin
        errors++;
        $display("FAIL wrap_waddr[%0d]: waddr=%0d wr_en=%b, want %0d 1", i, waddr, wr_en, i);
      end
      tick();
    end
    wr_push = 1'b0;
    checks++;
    if (wptr_gray !== 4'h0 || full !== 1'b1 || wr_level !== 4'd8) begin
      errors++;
      $display("FAIL wrap_full: gray=%h full=%b level=%0d, want 0 1 8", wptr_gray, full, wr_level);
    end
  endtask

  // Random pushes against a model read side whose pointer reaches this domain two edges late.
  task automatic test_random();
    logic [3:0] m_wbin, m_rbin, s1, s2, wbin_n, lvl_n;
    logic       m_full, push, rd, acc, full_n;
    do_reset();
    m_wbin = '0; m_rbin = '0; s1 = '0; s2 = '0; m_full = 1'b0;
    for (int c = 0; c < 400; c++) begin
      push = ($urandom_range(0, 2) != 0);
      rd   = ($urandom_range(0, 1) != 0) && (m_rbin != m_wbin);
      wr_push = push;
      rptr_gray_sync = tb_b2g(s2);
      #1;
      acc = push & ~m_full;
      checks++;
      if (wr_en !== acc) begin
        errors++;
        $display("FAIL rand_accept[%0d]: wr_en=%b want %b (push=%b full_model=%b)", c, wr_en, acc, push, m_full);
      end
      wbin_n = m_wbin + 4'(acc);
      lvl_n  = wbin_n - s2;
      full_n = (lvl_n == 4'd8);
      tick();
      s2 = s1;
      s1 = m_rbin;
      m_rbin = m_rbin + 4'(rd);
      m_wbin = wbin_n;
      m_full = full_n;
      checks++;
      if (wr_level !== lvl_n || full !== full_n || wptr_gray !== tb_b2g(m_wbin)) begin
        errors++;
        $display("FAIL rand_state[%0d]: level=%0d full=%b gray=%h, want %0d %b %h",
                 c, wr_level, full, wptr_gray, lvl_n, full_n, tb_b2g(m_wbin));
      end
    end
    wr_push = 1'b0;
  endtask

  initial begin
    arst = 1'b0;
    wr_push = 1'b0;
    ovf_clr = 1'b0;
    rptr_gray_sync = 4'h0;
    test_reset();
    test_fill();
    test_overflow();
    test_drain();
    test_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/async_fifo_wctrl.md
Name: async_fifo_wctrl

Overview:
Write-domain controller for the team's gray-pointer asynchronous FIFO. It owns the write pointer and generates the dual-port RAM write strobe and address. It publishes the registered gray write pointer, which the read domain samples through a 2-flop synchronizer. It takes in the read pointer, already synchronized into this clock, and derives full, almost-full, fill level and a sticky overflow flag.

Parameters:
ADDR_W, 3, RAM address width; FIFO depth = 2**ADDR_W; pointers are ADDR_W+1 bits
AFULL_THRESH, 6, level at or above which almost_full asserts; legal range 1..2**ADDR_W

Ports:
clk  in  1  write-domain clock
arst  in  1  reset; asynchronous, active-low
wr_push  in  1  request to write one word this cycle
ovf_clr  in  1  clears the sticky overflow flag
rptr_gray_sync  in  ADDR_W+1  read pointer (gray), output of the synchronizer into clk domain
wr_en  out  1  RAM write strobe
waddr  out  ADDR_W  RAM write address
wptr_gray  out  ADDR_W+1  registered gray write pointer, to the read-domain synchronizer
wr_ready  out  1  not full
full  out  1  registered full flag
almost_full  out  1  registered, level >= AFULL_THRESH
wr_level  out  ADDR_W+1  registered fill level seen from the write side
overflow  out  1  sticky: a push was dropped

Behaviour:
- Reset (arst low, asynchronous):
  - wbin, wptr_gray, full, almost_full, wr_level and overflow clear to 0.
  - wr_ready = 1.
  - The read domain must be reset in the same window. Resetting one side alone is a system error and is not detected.
- accept = wr_push & ~full. wr_en = accept (combinational). waddr = wbin[ADDR_W-1:0] (current pointer).
- Pointer update:
  - wbin_next = wbin + accept, modulo 2**(ADDR_W+1).
  - gray_next = wbin_next ^ (wbin_next >> 1).
  - wbin and wptr_gray register wbin_next and gray_next every cycle.
  - wptr_gray changes by at most one bit per cycle and comes straight from a flop, with no logic between the flop and the port.
- Full:
  - full <= (gray_next == {~rptr_gray_sync[ADDR_W:ADDR_W-1], rptr_gray_sync[ADDR_W-2:0]}).
  - full asserts the cycle after the accepted push that fills the FIFO. A push in the same cycle as full=1 is never accepted.
- Level:
  - rbin_sync = gray-to-binary of rptr_gray_sync (combinational).
  - wr_level <= wbin_next - rbin_sync, modulo 2**(ADDR_W+1). Maximum value 2**ADDR_W.
  - almost_full <= (that same value >= AFULL_THRESH).
- Flag behaviour is pessimistic by design:
  - full and level deassert or decrease only after a read becomes visible through the synchronizer, i.e. 2 clk cycles of latency plus this register.
  - The synchronized read pointer may jump several codes between consecutive clk edges. Level math handles this without special cases.
- Overflow:
  - Set when wr_push & full; the word is dropped and the pointer is unchanged.
  - Cleared when ovf_clr & ~(wr_push & full). When set and clear coincide, set wins.
- Wrap: the pointer MSB toggles every 2**ADDR_W writes, and full/level stay correct across wrap.

Decomposition:
- Shared package fifo_pkg:
  - constant PTR_W = ADDR_W+1 (used for the pointer typedef)
  - typedef ptr_t
  - functions bin2gray and gray2bin, also used by the read-side controller.
- One natural sub-module: async_fifo_ptr. It holds the binary/gray pointer register pair with an increment enable and is reused unchanged by the read side.
- The existing synchronizer is instantiated at FIFO top level, not inside this block.

Test Plan:
1. arst low mid-cycle with wr_push=1 → all outputs clear immediately (wptr_gray=0, full=0, wr_ready=1, wr_level=0); release → first push writes waddr=0.
2. rptr_gray_sync=0, 8 consecutive pushes (ADDR_W=3):
   - waddr 0..7
   - wptr_gray sequence 1,3,2,6,7,5,4,C
   - almost_full=1 the cycle after the 6th push
   - full=1 and wr_level=8 the cycle after the 8th push
   - wr_ready=0.
3. While full, wr_push=1 → wr_en=0, wptr_gray holds at C, overflow=1. Then wr_push=1 with ovf_clr=1 → overflow stays 1. Then ovf_clr alone → overflow=0.
4. While full, drive rptr_gray_sync=4'b0001 → full=0 and wr_level=7 the next cycle; almost_full stays 1. Drive rptr_gray_sync=4'b0011 → wr_level=6. Drive 4'b0010 → wr_level=5 and almost_full=0.
5. Wrap: set rptr_gray_sync=C with wbin=8 → level 0. Push 8 more → wptr_gray returns to 0 and full=1 (C maps to compare value 0).
6. Random push pattern against a reference model of a read side with a 2-cycle synchronizer delay → no accepted push while full, no drop while not full, wr_level always equals the model's level.
